adc_init_seq: RTL and testbench
===============================

Name: adc_init_seq

Overview:
- Responder to the ADC initialization handshake. Receives ADC_INIT and ADC_RST from the ADC init FSM in the reset manager and returns INIT_DONE.
- Plays a fixed table of 24-bit register writes (16-bit instruction + 8-bit data) to the front-end ADCs over a 3-wire serial port.
- All chip selects are driven together (broadcast write).
- Sits in the 40 MHz CLK domain beside the reset manager.

Parameters:
NUM_CMDS, 4, number of table entries played per init (must be >= 1)
NUM_ADC, 6, number of ADC chip selects (all driven identically)
CLK_DIV, 4, SCLK half-period in CLK cycles (must be >= 1)
GAP_CYC, 8, CSB-high gap between frames in CLK cycles (must be >= 1)

Ports:
CLK  in  1  40 MHz system clock
EOS  in  1  asynchronous active-low reset (end-of-startup)
ADC_INIT  in  1  level init request from ADC init FSM
ADC_RST  in  1  synchronous abort/hold-off, active high
INIT_DONE  out  1  init complete; held until ADC_INIT falls
BUSY  out  1  high from LOAD through the last GAP
CMD_IDX  out  clog2(NUM_CMDS)+1  index of the current/next table entry
ADC_SCLK  out  1  serial clock, idle low
ADC_SDATA  out  1  serial data, MSB first
ADC_CSB  out  NUM_ADC  chip selects, active low, idle all ones

Behaviour:
- EOS low (async): state IDLE, ADC_CSB all 1, ADC_SCLK 0, ADC_SDATA 0, INIT_DONE 0, BUSY 0, CMD_IDX 0, init_q 0.
- Edge detect: init_q <= ADC_INIT every cycle. A start occurs only when ADC_INIT=1, init_q=0, state IDLE and ADC_RST=0. Level-high alone never restarts.
- States: IDLE, LOAD, CS_SETUP, SHIFT, CS_HOLD, GAP, DONE.
- IDLE:
  - On start, go to LOAD with CMD_IDX=0.
  - ADC_INIT already high when EOS releases gives no start; ADC_INIT must go low then high.
- LOAD (1 cycle): shift register <= rom[CMD_IDX] (registered ROM output), bit counter 0, BUSY=1.
- CS_SETUP (CLK_DIV cycles): ADC_CSB all 0, ADC_SDATA=bit23, ADC_SCLK 0.
- SHIFT (24 bits x 2*CLK_DIV cycles):
  - Each bit spends CLK_DIV cycles with SCLK high, then CLK_DIV cycles with SCLK low.
  - ADC_SDATA advances to the next bit on the cycle SCLK goes high-to-low; the ADC samples on the rising edge.
  - After bit 0's low phase, go to CS_HOLD.
- CS_HOLD (CLK_DIV cycles): CSB stays low, SCLK low.
- GAP (GAP_CYC cycles): CSB all 1. On exit, CMD_IDX++. If CMD_IDX==NUM_CMDS go to DONE, else LOAD.
- Frame cost: 1+50*CLK_DIV+GAP_CYC cycles (209 at defaults).
- Timing: INIT_DONE goes high NUM_CMDS*frame+1 cycles after the edge that samples ADC_INIT high.
- DONE: INIT_DONE=1, BUSY=0. When ADC_INIT=0, go to IDLE (INIT_DONE 0, CMD_IDX 0) on the next edge.
- Abort:
  - ADC_RST=1 or ADC_INIT=0 in any state other than IDLE/DONE forces IDLE on the next edge.
  - On abort, CSB all 1, SCLK 0, SDATA 0, INIT_DONE 0, CMD_IDX 0. No partial frame is completed.
- Priority: ADC_RST beats start when both are asserted in the same cycle. ADC_RST in DONE also returns to IDLE.
- Counters:
  - Half-period counter is clog2(CLK_DIV) bits and reloads on every phase change.
  - Bit counter is 5 bits, terminal at 23.
  - No wrap beyond NUM_CMDS.

Decomposition:
- Package adc_init_pkg holds:
  - the state encoding;
  - the frame width constant (24);
  - the default command table ADC_CMD_TBL: {0x0000,0x3C} soft reset, {0x0014,0x01} output twos-complement, {0x000D,0x00} test pattern off, {0x00FF,0x01} transfer.
- Sub-module adc_cmd_rom: registered lookup CMD_IDX -> 24-bit word, 1-cycle latency, absorbed by LOAD.

Test Plan:
- Defaults, ADC_INIT rises at cycle 0 -> LOAD at 1, first CSB fall at 2. Four frames of 24 SCLK rises each, CSB low for 200 cycles per frame. INIT_DONE=1 at cycle 837.
- Check serial payload: decode SDATA on SCLK rising edges -> 0x00003C, 0x001401, 0x000D00, 0x00FF01 in order, MSB first. SDATA is stable for >=CLK_DIV cycles around each rise.
- ADC_INIT drops at cycle 300 (mid frame 2) -> next edge CSB=all ones, SCLK=0, BUSY=0, CMD_IDX=0, INIT_DONE stays 0. Re-raising ADC_INIT restarts from entry 0.
- ADC_RST and a rising ADC_INIT in the same cycle -> no start, all outputs stay at idle values. A later clean rising edge starts normally.
- EOS asserted mid-SHIFT -> all outputs at reset values asynchronously, before the next CLK edge.
- ADC_INIT held high after INIT_DONE -> INIT_DONE held, no replay. ADC_INIT low -> INIT_DONE=0 one cycle later. NUM_CMDS=1, CLK_DIV=1 -> INIT_DONE at cycle 60.

Source files
------------

// File: rtl/adc_init_pkg.sv
// rtl/adc_init_pkg.sv - state encoding and register-write table for the ADC init sequencer
package adc_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    localparam int FRAME_W = 24;
    localparam int TBL_LEN = 4;
    localparam int TBL_AW  = 2;

    // {instruction[15:0], data[7:0]}: soft reset, twos-complement out, test pattern off, transfer
    localparam logic [TBL_LEN-1:0][FRAME_W-1:0] ADC_CMD_TBL = {
        24'h00FF01,
        24'h000D00,
        24'h001401,
        24'h00003C
    };

endpackage

// File: rtl/adc_init_seq_rom.sv
// rtl/adc_init_seq_rom.sv - registered command-table lookup, one cycle of latency
module adc_cmd_rom
    import adc_init_pkg::*;
#(
    parameter int NUM_CMDS = 4,
    parameter int IDX_W    = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [FRAME_W-1:0] word_o
);

    logic [FRAME_W-1:0] word_d;
    logic [FRAME_W-1:0] word_q;

    // Indices past the played range (including the terminal NUM_CMDS value) read as zero
    always_comb begin
        word_d = '0;
        for (int i = 0; i < TBL_LEN; i++) begin
            if (i < NUM_CMDS && idx_i == IDX_W'(i)) begin
                word_d = ADC_CMD_TBL[TBL_AW'(i)];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/adc_init_seq.sv
// rtl/adc_init_seq.sv - plays the ADC register-write table over a broadcast 3-wire port on init request
module adc_init_seq
    import adc_init_pkg::*;
#(
    parameter int NUM_CMDS = 4,
    parameter int NUM_ADC  = 6,
    parameter int CLK_DIV  = 4,
    parameter int GAP_CYC  = 8
) (
    input  logic                      CLK,
    input  logic                      EOS,
    input  logic                      ADC_INIT,
    input  logic                      ADC_RST,
    output logic                      INIT_DONE,
    output logic                      BUSY,
    output logic [$clog2(NUM_CMDS):0] CMD_IDX,
    output logic                      ADC_SCLK,
    output logic                      ADC_SDATA,
    output logic [NUM_ADC-1:0]        ADC_CSB
);

    localparam int IDX_W = $clog2(NUM_CMDS) + 1;
    localparam int HC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GC_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(CLK_DIV - 1);
    localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(GAP_CYC - 1);
    localparam logic [4:0]       BIT_LAST = 5'(FRAME_W - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_CMDS);

    seq_state_e         state_q, state_d;
    logic               init_q;
    logic               armed_q;
    logic [IDX_W-1:0]   cmd_idx_q, cmd_idx_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               sclk_q, sclk_d;
    logic [HC_W-1:0]    hcnt_q, hcnt_d;
    logic [GC_W-1:0]    gcnt_q, gcnt_d;
    logic [4:0]         bit_q, bit_d;
    logic [FRAME_W-1:0] rom_word;
    logic [IDX_W-1:0]   idx_inc;
    logic               start;
    logic               abort;
    logic               in_frame;

    // Addressed with the next index so the word is ready during the single LOAD cycle
    adc_cmd_rom #(
        .NUM_CMDS (NUM_CMDS),
        .IDX_W    (IDX_W)
    ) u_rom (
        .clk_i  (CLK),
        .rst_ni (EOS),
        .idx_i  (cmd_idx_d),
        .word_o (rom_word)
    );

    // armed_q blocks a start from an ADC_INIT level that was already high out of reset
    assign start    = ADC_INIT && !init_q && armed_q && !ADC_RST;
    assign abort    = ADC_RST || !ADC_INIT;
    assign idx_inc  = cmd_idx_q + 1'b1;
    assign in_frame = (state_q != ST_IDLE) && (state_q != ST_DONE);

    always_comb begin
        state_d   = state_q;
        cmd_idx_d = cmd_idx_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        hcnt_d    = hcnt_q;
        gcnt_d    = gcnt_q;
        bit_d     = bit_q;

        case (state_q)
            ST_IDLE: begin
                cmd_idx_d = '0;
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d = rom_word;
                bit_d   = '0;
                hcnt_d  = '0;
                state_d = ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
                if (hcnt_q == HC_LAST) begin
                    hcnt_d  = '0;
                    sclk_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (hcnt_q == HC_LAST) begin
                    hcnt_d = '0;
                    if (sclk_q) begin
                        // Data moves on the falling edge so it is settled at the ADC's rising sample
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            ST_CS_HOLD: begin
                if (hcnt_q == HC_LAST) begin
                    hcnt_d  = '0;
                    gcnt_d  = '0;
                    state_d = ST_GAP;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GC_LAST) begin
                    gcnt_d    = '0;
                    cmd_idx_d = idx_inc;
                    state_d   = (idx_inc == IDX_END) ? ST_DONE : ST_LOAD;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    cmd_idx_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort drops the frame immediately; the port returns to idle levels on the next edge
        if (in_frame && abort) begin
            state_d   = ST_IDLE;
            cmd_idx_d = '0;
            shift_d   = '0;
            sclk_d    = 1'b0;
            hcnt_d    = '0;
            gcnt_d    = '0;
            bit_d     = '0;
        end
    end

    always_ff @(posedge CLK or negedge EOS) begin
        if (!EOS) begin
            state_q   <= ST_IDLE;
            init_q    <= 1'b0;
            armed_q   <= 1'b0;
            cmd_idx_q <= '0;
            shift_q   <= '0;
            sclk_q    <= 1'b0;
            hcnt_q    <= '0;
            gcnt_q    <= '0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            init_q    <= ADC_INIT;
            armed_q   <= armed_q || !ADC_INIT;
            cmd_idx_q <= cmd_idx_d;
            shift_q   <= shift_d;
            sclk_q    <= sclk_d;
            hcnt_q    <= hcnt_d;
            gcnt_q    <= gcnt_d;
            bit_q     <= bit_d;
        end
    end

    assign INIT_DONE = (state_q == ST_DONE);
    assign BUSY      = in_frame;
    assign CMD_IDX   = cmd_idx_q;
    assign ADC_SCLK  = sclk_q;
    assign ADC_SDATA = shift_q[FRAME_W-1];
    assign ADC_CSB   = ((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_CS_HOLD))
                       ? '0 : '1;

endmodule

// File: tb/tb_adc_init_seq.sv
// tb/tb_adc_init_seq.sv - directed self-checking bench for adc_init_seq
module tb_adc_init_seq;

    localparam int CLK_DIV = 4;

    logic       CLK = 1'b0;
    logic       EOS, ADC_INIT, ADC_RST, ADC_INIT1;
    logic       INIT_DONE, BUSY, ADC_SCLK, ADC_SDATA;
    logic [2:0] CMD_IDX;
    logic [5:0] ADC_CSB;
    logic       done1, busy1, sclk1, sdata1;
    logic [0:0] cmd_idx1;
    logic [5:0] csb1;

    always #5 CLK = ~CLK;

    adc_init_seq u_dut (
        .CLK(CLK), .EOS(EOS), .ADC_INIT(ADC_INIT), .ADC_RST(ADC_RST),
        .INIT_DONE(INIT_DONE), .BUSY(BUSY), .CMD_IDX(CMD_IDX),
        .ADC_SCLK(ADC_SCLK), .ADC_SDATA(ADC_SDATA), .ADC_CSB(ADC_CSB)
    );

    adc_init_seq #(.NUM_CMDS(1), .NUM_ADC(6), .CLK_DIV(1), .GAP_CYC(8)) u_dut1 (
        .CLK(CLK), .EOS(EOS), .ADC_INIT(ADC_INIT1), .ADC_RST(ADC_RST),
        .INIT_DONE(done1), .BUSY(busy1), .CMD_IDX(cmd_idx1),
        .ADC_SCLK(sclk1), .ADC_SDATA(sdata1), .ADC_CSB(csb1)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc, rise_cnt, csb_low, stab_err, since_chg, since_rise, first_done;
    logic        prev_sclk = 1'b0, prev_sdata = 1'b0;
    logic [23:0] word_sr;
    logic [23:0] words [4];

    task automatic clear_mon();
        rise_cnt = 0; csb_low = 0; stab_err = 0; since_chg = 100; since_rise = 100;
        first_done = -1; word_sr = '0;
        for (int i = 0; i < 4; i++) words[i] = '0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
        cyc++; since_chg++; since_rise++;
        if (ADC_CSB == 6'h00) csb_low++;
        if (ADC_SDATA !== prev_sdata && ADC_CSB == 6'h00) begin
            if (since_rise < CLK_DIV) stab_err++;
            since_chg = 0;
        end
        if (ADC_SCLK === 1'b1 && prev_sclk === 1'b0) begin
            if (since_chg < CLK_DIV) stab_err++;
            since_rise = 0;
            word_sr = {word_sr[22:0], ADC_SDATA};
            rise_cnt++;
            if (rise_cnt % 24 == 0 && rise_cnt / 24 <= 4) words[rise_cnt/24 - 1] = word_sr;
        end
        if (INIT_DONE === 1'b1 && first_done < 0) first_done = cyc;
        prev_sclk = ADC_SCLK; prev_sdata = ADC_SDATA;
    endtask

    task automatic test_reset();
        EOS = 1'b0; ADC_INIT = 1'b0; ADC_RST = 1'b0; ADC_INIT1 = 1'b0;
        tick(); tick();
        n_cmp++; if (ADC_CSB !== 6'h3F) begin n_fail++; $display("FAIL reset_csb: got %h want 3f", ADC_CSB); end
        n_cmp++; if (ADC_SCLK !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", ADC_SCLK); end
        n_cmp++; if (ADC_SDATA !== 1'b0) begin n_fail++; $display("FAIL reset_sdata: got %b want 0", ADC_SDATA); end
        n_cmp++; if (INIT_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", INIT_DONE); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (CMD_IDX !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", CMD_IDX); end
        EOS = 1'b1;
        tick(); tick();
    endtask

    task automatic test_init_high_at_release();
        EOS = 1'b0; ADC_INIT = 1'b1;
        tick();
        EOS = 1'b1;
        repeat (5) tick();
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL level_no_start_busy: got %b want 0", BUSY); end
        n_cmp++; if (ADC_CSB !== 6'h3F) begin n_fail++; $display("FAIL level_no_start_csb: got %h want 3f", ADC_CSB); end
        ADC_INIT = 1'b0; tick();
        ADC_INIT = 1'b1; tick();
        n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL rearm_start_busy: got %b want 1", BUSY); end
        ADC_INIT = 1'b0; tick();
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rearm_abort_busy: got %b want 0", BUSY); end
        tick();
    endtask

    task automatic test_full_init();
        clear_mon(); cyc = 0;
        ADC_INIT = 1'b1;
        tick();
        n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", BUSY); end
        n_cmp++; if (ADC_CSB !== 6'h3F) begin n_fail++; $display("FAIL load_csb: got %h want 3f", ADC_CSB); end
        tick();
        n_cmp++; if (ADC_CSB !== 6'h00) begin n_fail++; $display("FAIL cs_fall_at_2: got %h want 00", ADC_CSB); end
        while (first_done < 0 && cyc < 1000) tick();
        n_cmp++; if (first_done !== 837) begin n_fail++; $display("FAIL done_cycle: got %0d want 837", first_done); end
        n_cmp++; if (rise_cnt !== 96) begin n_fail++; $display("FAIL sclk_rises: got %0d want 96", rise_cnt); end
        n_cmp++; if (csb_low !== 800) begin n_fail++; $display("FAIL csb_low_cycles: got %0d want 800", csb_low); end
        n_cmp++; if (words[0] !== 24'h00003C) begin n_fail++; $display("FAIL word0: got %h want 00003c", words[0]); end
        n_cmp++; if (words[1] !== 24'h001401) begin n_fail++; $display("FAIL word1: got %h want 001401", words[1]); end
        n_cmp++; if (words[2] !== 24'h000D00) begin n_fail++; $display("FAIL word2: got %h want 000d00", words[2]); end
        n_cmp++; if (words[3] !== 24'h00FF01) begin n_fail++; $display("FAIL word3: got %h want 00ff01", words[3]); end
        n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL sdata_stability: got %0d errors want 0", stab_err); end
        n_cmp++; if (CMD_IDX !== 3'd4) begin n_fail++; $display("FAIL done_idx: got %0d want 4", CMD_IDX); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL done_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_hold_after_done();
        int hold_err = 0;
        repeat (40) begin
            tick();
            if (INIT_DONE !== 1'b1 || BUSY !== 1'b0 || ADC_CSB !== 6'h3F) hold_err++;
        end
        n_cmp++; if (hold_err !== 0) begin n_fail++; $display("FAIL hold_done: got %0d bad cycles want 0", hold_err); end
        n_cmp++; if (rise_cnt !== 96) begin n_fail++; $display("FAIL no_replay: got %0d rises want 96", rise_cnt); end
        ADC_INIT = 1'b0; tick();
        n_cmp++; if (INIT_DONE !== 1'b0) begin n_fail++; $display("FAIL done_release: got %b want 0", INIT_DONE); end
        n_cmp++; if (CMD_IDX !== 3'd0) begin n_fail++; $display("FAIL done_release_idx: got %0d want 0", CMD_IDX); end
    endtask

    task automatic test_abort_init_low();
        clear_mon(); cyc = 0;
        ADC_INIT = 1'b1;
        while (cyc < 300) tick();
        n_cmp++; if (CMD_IDX !== 3'd1) begin n_fail++; $display("FAIL mid_frame2_idx: got %0d want 1", CMD_IDX); end
        ADC_INIT = 1'b0; tick();
        n_cmp++; if (ADC_CSB !== 6'h3F) begin n_fail++; $display("FAIL abort_csb: got %h want 3f", ADC_CSB); end
        n_cmp++; if (ADC_SCLK !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b want 0", ADC_SCLK); end
        n_cmp++; if (ADC_SDATA !== 1'b0) begin n_fail++; $display("FAIL abort_sdata: got %b want 0", ADC_SDATA); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", BUSY); end
        n_cmp++; if (CMD_IDX !== 3'd0) begin n_fail++; $display("FAIL abort_idx: got %0d want 0", CMD_IDX); end
        n_cmp++; if (INIT_DONE !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", INIT_DONE); end
        tick();
        clear_mon(); cyc = 0;
        ADC_INIT = 1'b1; tick();
        n_cmp++; if (BUSY !== 1'b1 || CMD_IDX !== 3'd0) begin n_fail++; $display("FAIL restart: got busy=%b idx=%0d want busy=1 idx=0", BUSY, CMD_IDX); end
        while (rise_cnt < 24 && cyc < 400) tick();
        n_cmp++; if (words[0] !== 24'h00003C) begin n_fail++; $display("FAIL restart_word0: got %h want 00003c", words[0]); end
        ADC_INIT = 1'b0; tick();
    endtask

    task automatic test_rst_vs_start();
        ADC_RST = 1'b1; ADC_INIT = 1'b1; tick();
        n_cmp++; if (BUSY !== 1'b0 || ADC_CSB !== 6'h3F || CMD_IDX !== 3'd0) begin
            n_fail++; $display("FAIL rst_beats_start: got busy=%b csb=%h idx=%0d want 0 3f 0", BUSY, ADC_CSB, CMD_IDX); end
        repeat (3) tick();
        ADC_RST = 1'b0; repeat (3) tick();
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_level_no_start: got %b want 0", BUSY); end
        ADC_INIT = 1'b0; tick();
        cyc = 0; ADC_INIT = 1'b1; tick();
        n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL clean_start_after_rst: got %b want 1", BUSY); end
        while (cyc < 20) tick();
        n_cmp++; if (ADC_CSB !== 6'h00) begin n_fail++; $display("FAIL shift_csb: got %h want 00", ADC_CSB); end
        ADC_RST = 1'b1; tick();
        n_cmp++; if (BUSY !== 1'b0 || ADC_CSB !== 6'h3F || ADC_SCLK !== 1'b0 || ADC_SDATA !== 1'b0) begin
            n_fail++; $display("FAIL rst_abort: got busy=%b csb=%h sclk=%b sdata=%b want 0 3f 0 0", BUSY, ADC_CSB, ADC_SCLK, ADC_SDATA); end
        ADC_RST = 1'b0; ADC_INIT = 1'b0; tick();
    endtask

    task automatic test_eos_async();
        cyc = 0; ADC_INIT = 1'b1;
        while (cyc < 16) tick();
        n_cmp++; if (ADC_SCLK !== 1'b1) begin n_fail++; $display("FAIL pre_eos_sclk: got %b want 1", ADC_SCLK); end
        #2 EOS = 1'b0;
        #1;
        n_cmp++; if (ADC_CSB !== 6'h3F || ADC_SCLK !== 1'b0 || ADC_SDATA !== 1'b0) begin
            n_fail++; $display("FAIL eos_async_port: got csb=%h sclk=%b sdata=%b want 3f 0 0", ADC_CSB, ADC_SCLK, ADC_SDATA); end
        n_cmp++; if (BUSY !== 1'b0 || CMD_IDX !== 3'd0 || INIT_DONE !== 1'b0) begin
            n_fail++; $display("FAIL eos_async_status: got busy=%b idx=%0d done=%b want 0 0 0", BUSY, CMD_IDX, INIT_DONE); end
        ADC_INIT = 1'b0; tick();
        EOS = 1'b1; tick(); tick();
    endtask

    task automatic test_small_config();
        int first1 = -1;
        ADC_INIT1 = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (done1 === 1'b1 && first1 < 0) first1 = c;
        end
        n_cmp++; if (first1 !== 60) begin n_fail++; $display("FAIL small_done_cycle: got %0d want 60", first1); end
        n_cmp++; if (cmd_idx1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL small_done_state: got idx=%0d busy=%b want 1 0", cmd_idx1, busy1); end
        n_cmp++; if (csb1 !== 6'h3F || sclk1 !== 1'b0 || sdata1 !== 1'b0) begin
            n_fail++; $display("FAIL small_idle_port: got csb=%h sclk=%b sdata=%b want 3f 0 0", csb1, sclk1, sdata1); end
        ADC_INIT1 = 1'b0; tick();
        n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL small_release: got %b want 0", done1); end
    endtask

    initial begin
        cyc = 0;
        clear_mon();
        test_reset();
        test_init_high_at_release();
        test_full_init();
        test_hold_after_done();
        test_abort_init_low();
        test_rst_vs_start();
        test_eos_async();
        test_small_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
